// File: rtl/adi2axis_pkg.sv
// rtl/adi2axis_pkg.sv - shared constants for the ADI DMA to AXI-Stream bridge
package adi2axis_pkg;

  // Width of the beat counter and latched packet length
  localparam int PKT_CNT_W = 16;

  // Write-side FSM encoding
  localparam logic [0:0] ST_WAIT_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN       = 1'b1;

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - first-word-fall-through synchronous FIFO
module axis_sync_fifo #(
  parameter int DATA_WIDTH = 65,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push, pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for the write
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;
  // Head is forced to zero when empty so stale entries never leak onto the bus
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/adi2axis.sv
// rtl/adi2axis.sv - ADI DMA write port to AXI4-Stream master with packet framing
module adi2axis
  import adi2axis_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_NUM_BYTES = 8,
  parameter int C_FIFO_ADDR_WIDTH        = 4,
  parameter int C_WAIT_SYNC              = 1
) (
  input  logic                                  AXIS_ACLK,
  input  logic                                  AXIS_ARESETN,
  input  logic                                  dma_wr,
  input  logic                                  dma_sync,
  input  logic [8*C_M_AXIS_TDATA_NUM_BYTES-1:0] dma_data,
  output logic                                  dma_ovf,
  input  logic [PKT_CNT_W-1:0]                  pkt_len,
  output logic                                  M_AXIS_TVALID,
  input  logic                                  M_AXIS_TREADY,
  output logic [8*C_M_AXIS_TDATA_NUM_BYTES-1:0] M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TSTRB,
  output logic                                  M_AXIS_TLAST
);

  localparam int W = 8 * C_M_AXIS_TDATA_NUM_BYTES;
  localparam logic [0:0] ST_RESET = (C_WAIT_SYNC != 0) ? ST_WAIT_SYNC : ST_RUN;

  logic [0:0]           state_q, state_d;
  logic [PKT_CNT_W-1:0] cnt_q, cnt_d;
  logic [PKT_CNT_W-1:0] len_q, len_d;
  logic [PKT_CNT_W-1:0] len_eff;
  logic                 ovf_q;
  logic                 capture, wr_req, fifo_full, fifo_empty, accept, drop, beat_last;
  logic [W:0]           fifo_rd_data;

  // While waiting for sync only the sync-qualified beat gets through
  assign capture = (state_q == ST_RUN) | dma_sync;
  assign wr_req  = dma_wr & capture;
  assign accept  = wr_req & ~fifo_full;
  assign drop    = wr_req & fifo_full;

  // Length is taken from pkt_len only at packet start; zero means single-beat packets
  assign len_eff   = (cnt_q == '0) ? ((pkt_len == '0) ? PKT_CNT_W'(1) : pkt_len) : len_q;
  assign beat_last = (cnt_q == len_eff - PKT_CNT_W'(1));

  // FSM, beat counter and length latch next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (state_q == ST_WAIT_SYNC && dma_wr && dma_sync) state_d = ST_RUN;
    if (accept) begin
      len_d = len_eff;
      cnt_d = beat_last ? '0 : cnt_q + PKT_CNT_W'(1);
    end
  end

  // Control registers
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= drop;
    end
  end

  axis_sync_fifo #(
    .DATA_WIDTH (W + 1),
    .ADDR_WIDTH (C_FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .wr_en   (wr_req),
    .wr_data ({beat_last, dma_data}),
    .full    (fifo_full),
    .rd_en   (M_AXIS_TREADY),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  assign dma_ovf       = ovf_q;
  assign M_AXIS_TVALID = ~fifo_empty;
  assign M_AXIS_TDATA  = fifo_rd_data[W-1:0];
  assign M_AXIS_TLAST  = fifo_rd_data[W];
  assign M_AXIS_TSTRB  = '1;

endmodule

// File: tb/tb_adi2axis.sv
// tb/tb_adi2axis.sv - scoreboard testbench for adi2axis
module tb_adi2axis;

  localparam int NB    = 8;
  localparam int W     = 8 * NB;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dma_wr, dma_sync;
  logic [W-1:0]  dma_data;
  logic          dma_ovf;
  logic [15:0]   pkt_len;
  logic          tvalid, tready, tlast;
  logic [W-1:0]  tdata;
  logic [NB-1:0] tstrb;

  int vectors     = 0;
  int miscompares = 0;
  int npop        = 0;
  int npush       = 0;

  logic [W:0] sb_q [$];

  logic m_run;
  int   m_cnt, m_len;

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;

  adi2axis #(
    .C_M_AXIS_TDATA_NUM_BYTES (NB),
    .C_FIFO_ADDR_WIDTH        (AW),
    .C_WAIT_SYNC              (1)
  ) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .dma_wr        (dma_wr),
    .dma_sync      (dma_sync),
    .dma_data      (dma_data),
    .dma_ovf       (dma_ovf),
    .pkt_len       (pkt_len),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TSTRB  (tstrb),
    .M_AXIS_TLAST  (tlast)
  );

  always #5 clk = ~clk;

  // Output monitor: handshakes and stall stability observed mid-cycle
  always @(negedge clk) begin
    logic [W:0] exp;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        vectors++;
        if (tvalid !== 1'b1 || tdata !== prev_data || tlast !== prev_last) begin
          miscompares++;
          $display("FAIL stall_stable: tvalid=%b tdata=%h tlast=%b, required tvalid=1 tdata=%h tlast=%b",
                   tvalid, tdata, tlast, prev_data, prev_last);
        end
      end
      if (tvalid === 1'b1 && tready === 1'b1) begin
        vectors++;
        npop++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: tdata=%h tlast=%b, required no beat", tdata, tlast);
        end else begin
          exp = sb_q.pop_front();
          if ({tlast, tdata} !== exp) begin
            miscompares++;
            $display("FAIL beat: tdata=%h tlast=%b, required tdata=%h tlast=%b",
                     tdata, tlast, exp[W-1:0], exp[W]);
          end
        end
      end
      prev_stall = (tvalid === 1'b1) && (tready !== 1'b1);
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  // One cycle of DMA input; predicts store/drop and checks dma_ovf after the edge
  task automatic drive(input logic wr, input logic sync, input logic [W-1:0] d);
    logic nxt_ovf;
    int   eff;
    logic tl;
    dma_wr   = wr;
    dma_sync = sync;
    dma_data = d;
    nxt_ovf  = 1'b0;
    if (wr && (m_run || sync)) begin
      m_run = 1'b1;
      if (sb_q.size() == DEPTH) begin
        nxt_ovf = 1'b1;
      end else begin
        eff = (m_cnt == 0) ? ((pkt_len == 16'd0) ? 1 : int'(pkt_len)) : m_len;
        if (m_cnt == 0) m_len = eff;
        tl    = (m_cnt == eff - 1);
        m_cnt = tl ? 0 : m_cnt + 1;
        sb_q.push_back({tl, d});
        npush++;
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (dma_ovf !== nxt_ovf) begin
      miscompares++;
      $display("FAIL dma_ovf: got %b, required %b", dma_ovf, nxt_ovf);
    end
  endtask

  task automatic drain();
    tready = 1'b1;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) drive(1'b0, 1'b0, '0);
    vectors++;
    if (sb_q.size() != 0 || tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: %0d beats outstanding tvalid=%b, required 0 and 0", sb_q.size(), tvalid);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== '0 || dma_ovf !== 1'b0 || tstrb !== {NB{1'b1}}) begin
      miscompares++;
      $display("FAIL reset_outputs: tvalid=%b tlast=%b tdata=%h ovf=%b tstrb=%h, required 0 0 0 0 ff",
               tvalid, tlast, tdata, dma_ovf, tstrb);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_wait_sync();
    int p0;
    p0      = npop;
    pkt_len = 16'd4;
    tready  = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, W'(64'h1111_0000 + i));
    drive(1'b1, 1'b1, 64'hA0A0_A0A0_0000_0000);
    for (int i = 1; i < 8; i++) drive(1'b1, (i == 5), 64'hA0A0_A0A0_0000_0000 + W'(i));
    drain();
    vectors++;
    if (npop - p0 != 8) begin
      miscompares++;
      $display("FAIL wait_sync_count: got %0d beats, required 8", npop - p0);
    end
  endtask

  task automatic test_overflow();
    int p0;
    tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 64'hB000_0000_0000_0000 + W'(i));
      vectors++;
      if (tvalid !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_tvalid: got %b, required 1", tvalid);
      end
    end
    p0 = npop;
    drain();
    vectors++;
    if (npop - p0 != DEPTH) begin
      miscompares++;
      $display("FAIL ovf_count: got %0d beats, required %0d", npop - p0, DEPTH);
    end
  endtask

  task automatic test_full_same_cycle();
    tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 64'hC000_0000_0000_0000 + W'(i));
    tready = 1'b1;
    drive(1'b1, 1'b0, 64'hC0DE_0000_0000_00FF);
    tready = 1'b0;
    drive(1'b1, 1'b0, 64'hC0DE_0000_0000_0100);
    drain();
  endtask

  task automatic test_len_change();
    tready  = 1'b1;
    pkt_len = 16'd4;
    for (int i = 0; i < 8 && m_cnt != 0; i++) drive(1'b1, 1'b0, 64'hD0D0_0000_0000_0000 + W'(i));
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 64'hD100_0000_0000_0000 + W'(i));
    pkt_len = 16'd2;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 64'hD200_0000_0000_0000 + W'(i));
    pkt_len = 16'd0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 64'hD300_0000_0000_0000 + W'(i));
    drain();
  endtask

  task automatic test_random();
    int n0;
    n0      = npush;
    pkt_len = 16'd7;
    for (int i = 0; i < 5000 && npush - n0 < 1000; i++) begin
      tready = ($urandom_range(0, 9) < 6);
      drive(($urandom_range(0, 9) < 7), 1'b0, {$urandom, $urandom});
    end
    drain();
    vectors++;
    if (npush - n0 < 1000) begin
      miscompares++;
      $display("FAIL random_count: got %0d beats, required 1000", npush - n0);
    end
  endtask

  task automatic test_reset_mid();
    tready  = 1'b0;
    pkt_len = 16'd4;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 64'hE000_0000_0000_0000 + W'(i));
    dma_wr = 1'b0;
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    m_run = 1'b0;
    m_cnt = 0;
    m_len = 0;
    #1;
    vectors++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: tvalid=%b tlast=%b tdata=%h, required 0 0 0", tvalid, tlast, tdata);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    tready = 1'b1;
    drive(1'b1, 1'b0, 64'hE100_0000_0000_0000);
    drive(1'b1, 1'b1, 64'hE200_0000_0000_0000);
    for (int i = 1; i < 6; i++) drive(1'b1, 1'b0, 64'hE200_0000_0000_0000 + W'(i));
    drain();
  endtask

  initial begin
    rst_n    = 1'b1;
    dma_wr   = 1'b0;
    dma_sync = 1'b0;
    dma_data = '0;
    pkt_len  = 16'd4;
    tready   = 1'b0;
    m_run    = 1'b0;
    m_cnt    = 0;
    m_len    = 0;
    #1;
    rst_n = 1'b0;
    test_reset();
    test_wait_sync();
    test_overflow();
    test_full_same_cycle();
    test_len_change();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
